// File: rtl/alu_sequential_pkg.sv
// Shared definitions for the sequential ALU: opcode map and control FSM states.
// No ports; imported by the top module.
package alu_sequential_pkg;

  typedef enum logic [3:0] {
    ALU_PASSA  = 4'd0,
    ALU_ADC    = 4'd1,
    ALU_ADD    = 4'd2,
    ALU_AND    = 4'd3,
    ALU_BIC    = 4'd4,
    ALU_SUB    = 4'd5,
    ALU_NEG    = 4'd6,
    ALU_ORR    = 4'd7,
    ALU_SBC    = 4'd8,
    ALU_MUL    = 4'd9,
    ALU_DIV    = 4'd10,
    ALU_MOD    = 4'd11,
    ALU_PASSB  = 4'd12,
    ALU_XOR    = 4'd13,
    ALU_LAND   = 4'd14,
    ALU_PASSA2 = 4'd15
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic is_div_op(opcode_t op);
    return (op == ALU_DIV) || (op == ALU_MOD);
  endfunction

endpackage

// File: rtl/alu_sequential_if.sv
// Request/response bundle between the issue stage and the sequential ALU.
//   start, control, channel_A, channel_B, CarryIn : request (master -> slave)
//   busy, done, outputALU, Negative/Zero/Carry/oVerflow : status and result (slave -> master)
interface alu_sequential_if #(parameter int DATA_WIDTH = 32);
  logic                  start;
  logic [3:0]            control;
  logic [DATA_WIDTH-1:0] channel_A;
  logic [DATA_WIDTH-1:0] channel_B;
  logic                  CarryIn;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] outputALU;
  logic                  Negative;
  logic                  Zero;
  logic                  Carry;
  logic                  oVerflow;

  modport master (
    output start, control, channel_A, channel_B, CarryIn,
    input  busy, done, outputALU, Negative, Zero, Carry, oVerflow
  );

  modport slave (
    input  start, control, channel_A, channel_B, CarryIn,
    output busy, done, outputALU, Negative, Zero, Carry, oVerflow
  );
endinterface

// File: rtl/alu_seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock.
//   clock, reset (sync, active-low), start : load operands and begin
//   dividend, divisor                      : operands sampled on start
//   quotient, remainder                    : valid while done is high
//   done                                   : high during the final iteration
// done and the results are presented combinationally during the last iteration
// so the caller can register them on the same edge that ends the division.
module alu_seq_divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  done
);
  localparam int CW = $clog2(DATA_WIDTH);

  logic                  active_q;
  logic [CW-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0] quo_q, rem_q, dsr_q;
  logic [DATA_WIDTH:0]   shifted, diff;

  always_comb begin
    shifted   = {rem_q, quo_q[DATA_WIDTH-1]};
    diff      = shifted - {1'b0, dsr_q};
    // diff[MSB] set means the trial subtraction went negative: restore.
    quotient  = {quo_q[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};
    remainder = diff[DATA_WIDTH] ? shifted[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
    done      = active_q && (cnt_q == '0);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dsr_q    <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      cnt_q    <= CW'(DATA_WIDTH - 1);
      quo_q    <= dividend;
      rem_q    <= '0;
      dsr_q    <= divisor;
    end else if (active_q) begin
      quo_q <= quotient;
      rem_q <= remainder;
      if (cnt_q == '0) active_q <= 1'b0;
      else             cnt_q    <= cnt_q - 1'b1;
    end
  end
endmodule

// File: rtl/alu_sequential.sv
// Clocked ALU with registered result/NZCV flags; MUL (shift-add) and DIV/MOD
// (restoring divider) iterate one bit per cycle, everything else completes in one.
//   clock, reset (sync, active-low)
//   bus : alu_sequential_if.slave (request, busy/done, result, flags)
import alu_sequential_pkg::*;

module alu_sequential #(
  parameter int DATA_WIDTH = 32
) (
  input logic             clock,
  input logic             reset,
  alu_sequential_if.slave bus
);
  localparam int CW = $clog2(DATA_WIDTH);

  state_t                state_q, state_d;
  opcode_t               op_in, op_q;
  logic                  accept, div_start, div_done;
  logic [DATA_WIDTH-1:0] div_quo, div_rem;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  n_q, z_q, c_q, v_q;
  logic [DATA_WIDTH-1:0] mul_acc_q, mul_a_q, mul_b_q, mul_acc_d;
  logic [CW-1:0]         mul_cnt_q;
  logic [DATA_WIDTH:0]   ext;
  logic [DATA_WIDTH-1:0] sc_result;
  logic                  sc_n, sc_z, sc_c, sc_v, arith, nz_en;

  assign op_in  = opcode_t'(bus.control);
  assign accept = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  always_ff @(posedge clock) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (bus.start) begin
          if (op_in == ALU_MUL) begin
            state_d = ST_MUL;
          end else if (is_div_op(op_in) && (bus.channel_B != '0)) begin
            state_d   = ST_DIV;
            div_start = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_MUL:  if (mul_cnt_q == '0) state_d = ST_DONE;
      ST_DIV:  if (div_done)        state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Single-cycle datapath. Arithmetic runs one bit wider so the top bit is the
  // carry (or borrow for subtracting ops).
  always_comb begin
    ext       = '0;
    sc_result = '0;
    arith     = 1'b0;
    nz_en     = 1'b1;
    sc_n      = 1'b0;
    sc_z      = 1'b0;
    sc_c      = 1'b0;
    sc_v      = 1'b0;
    case (op_in)
      ALU_ADC: begin
        ext   = {1'b0, bus.channel_A} + {1'b0, bus.channel_B} + {{DATA_WIDTH{1'b0}}, bus.CarryIn};
        arith = 1'b1;
      end
      ALU_ADD: begin
        ext   = {1'b0, bus.channel_A} + {1'b0, bus.channel_B};
        arith = 1'b1;
      end
      ALU_SUB: begin
        ext   = {1'b0, bus.channel_A} - {1'b0, bus.channel_B};
        arith = 1'b1;
      end
      ALU_NEG: begin
        ext   = '0 - {1'b0, bus.channel_A};
        arith = 1'b1;
      end
      ALU_SBC: begin
        ext   = {1'b0, bus.channel_A} - {1'b0, bus.channel_B} - {{DATA_WIDTH{1'b0}}, ~bus.CarryIn};
        arith = 1'b1;
      end
      ALU_AND:  sc_result = bus.channel_A & bus.channel_B;
      ALU_BIC:  sc_result = bus.channel_A & ~bus.channel_B;
      ALU_ORR:  sc_result = bus.channel_A | bus.channel_B;
      ALU_XOR:  sc_result = bus.channel_A ^ bus.channel_B;
      ALU_LAND: sc_result = DATA_WIDTH'((bus.channel_A != '0) && (bus.channel_B != '0));
      ALU_MUL:  sc_result = '0;
      // Only reached here for a zero divisor: result 0, V flags it.
      ALU_DIV, ALU_MOD: begin
        nz_en = 1'b0;
        sc_v  = (bus.channel_B == '0);
      end
      ALU_PASSB: begin
        sc_result = bus.channel_B;
        nz_en     = 1'b0;
      end
      default: sc_result = bus.channel_A;
    endcase
    if (arith) begin
      sc_result = ext[DATA_WIDTH-1:0];
      sc_c      = ext[DATA_WIDTH];
      sc_v      = ext[DATA_WIDTH-1] ^ ext[DATA_WIDTH];
    end
    if (nz_en) begin
      sc_n = sc_result[DATA_WIDTH-1];
      sc_z = (sc_result == '0);
    end
  end

  assign mul_acc_d = mul_acc_q + (mul_b_q[0] ? mul_a_q : '0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      op_q      <= ALU_PASSA;
      result_q  <= '0;
      n_q       <= 1'b0;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
      v_q       <= 1'b0;
      mul_acc_q <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      mul_cnt_q <= '0;
    end else if (accept) begin
      op_q      <= op_in;
      mul_acc_q <= '0;
      mul_a_q   <= bus.channel_A;
      mul_b_q   <= bus.channel_B;
      mul_cnt_q <= CW'(DATA_WIDTH - 1);
      if (state_d == ST_DONE) begin
        result_q <= sc_result;
        n_q      <= sc_n;
        z_q      <= sc_z;
        c_q      <= sc_c;
        v_q      <= sc_v;
      end
    end else if (state_q == ST_MUL) begin
      mul_acc_q <= mul_acc_d;
      mul_a_q   <= mul_a_q << 1;
      mul_b_q   <= mul_b_q >> 1;
      mul_cnt_q <= mul_cnt_q - 1'b1;
      if (mul_cnt_q == '0) begin
        result_q <= mul_acc_d;
        n_q      <= mul_acc_d[DATA_WIDTH-1];
        z_q      <= (mul_acc_d == '0);
        c_q      <= 1'b0;
        v_q      <= 1'b0;
      end
    end else if ((state_q == ST_DIV) && div_done) begin
      result_q <= (op_q == ALU_MOD) ? div_rem : div_quo;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
    end
  end

  alu_seq_divider #(.DATA_WIDTH(DATA_WIDTH)) u_divider (
    .clock     (clock),
    .reset     (reset),
    .start     (div_start),
    .dividend  (bus.channel_A),
    .divisor   (bus.channel_B),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  assign bus.busy      = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.outputALU = result_q;
  assign bus.Negative  = n_q;
  assign bus.Zero      = z_q;
  assign bus.Carry     = c_q;
  assign bus.oVerflow  = v_q;
endmodule

// File: tb/tb_alu_sequential.sv
// Self-checking bench for alu_sequential (DATA_WIDTH = 32): directed table,
// hand-written multi-cycle sequences, and random ops against a reference model.
module tb_alu_sequential;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_vec  = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;

  alu_sequential_if #(.DATA_WIDTH(32)) bus ();

  alu_sequential #(.DATA_WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] res;
    logic [3:0]  nzcv;
    int          lat;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [3:0] flags_now();
    return {bus.Negative, bus.Zero, bus.Carry, bus.oVerflow};
  endfunction

  // Reference model from the opcode definitions using wide integer arithmetic.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic cin, output logic [31:0] r, output logic [3:0] nzcv,
                                output int lat);
    logic [63:0] w;
    logic c, v, nz, ar;
    c = 1'b0; v = 1'b0; nz = 1'b1; ar = 1'b0; lat = 1; r = '0;
    case (op)
      4'd1:  begin w = 64'(a) + 64'(b) + 64'(cin); r = w[31:0]; c = w[32]; ar = 1'b1; end
      4'd2:  begin w = 64'(a) + 64'(b); r = w[31:0]; c = w[32]; ar = 1'b1; end
      4'd3:  r = a & b;
      4'd4:  r = a & ~b;
      4'd5:  begin r = a - b; c = (a < b); ar = 1'b1; end
      4'd6:  begin r = 32'd0 - a; c = (a != 0); ar = 1'b1; end
      4'd7:  r = a | b;
      4'd8:  begin r = a - b - 32'(!cin); c = (64'(a) < 64'(b) + 64'(!cin)); ar = 1'b1; end
      4'd9:  begin w = 64'(a) * 64'(b); r = w[31:0]; lat = 33; end
      4'd10: begin nz = 1'b0; v = (b == 0); r = (b == 0) ? 32'd0 : a / b; lat = (b == 0) ? 1 : 33; end
      4'd11: begin nz = 1'b0; v = (b == 0); r = (b == 0) ? 32'd0 : a % b; lat = (b == 0) ? 1 : 33; end
      4'd12: begin r = b; nz = 1'b0; end
      4'd13: r = a ^ b;
      4'd14: r = ((a != 0) && (b != 0)) ? 32'd1 : 32'd0;
      default: r = a;
    endcase
    if (ar) v = r[31] ^ c;
    nzcv = {nz & r[31], nz & (r == 0), c, v};
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, output logic [31:0] res, output logic [3:0] nzcv,
                        output int lat);
    @(negedge clock);
    bus.start = 1'b1; bus.control = op; bus.channel_A = a; bus.channel_B = b; bus.CarryIn = cin;
    @(posedge clock); #1;
    bus.start = 1'b0;
    bus.channel_A = $urandom; bus.channel_B = $urandom; bus.CarryIn = ~cin;
    lat = 1;
    while (!bus.done && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    res  = bus.outputALU;
    nzcv = flags_now();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, er, held;
    logic [3:0]  f, ef;
    int          lat, el, cyc, ndone, first;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        cin;

    tbl[0]  = '{4'd2,  32'h7FFFFFFF, 32'h1,        1'b0, 32'h80000000, 4'b1001, 1};
    tbl[1]  = '{4'd5,  32'd3,        32'd5,        1'b0, 32'hFFFFFFFE, 4'b1010, 1};
    tbl[2]  = '{4'd8,  32'd5,        32'd3,        1'b0, 32'd1,        4'b0000, 1};
    tbl[3]  = '{4'd9,  32'hFFFFFFFF, 32'd2,        1'b0, 32'hFFFFFFFE, 4'b1000, 33};
    tbl[4]  = '{4'd10, 32'd100,      32'd7,        1'b0, 32'd14,       4'b0000, 33};
    tbl[5]  = '{4'd11, 32'd100,      32'd7,        1'b0, 32'd2,        4'b0000, 33};
    tbl[6]  = '{4'd10, 32'd5,        32'd0,        1'b0, 32'd0,        4'b0001, 1};
    tbl[7]  = '{4'd11, 32'd9,        32'd0,        1'b1, 32'd0,        4'b0001, 1};
    tbl[8]  = '{4'd1,  32'hFFFFFFFF, 32'd0,        1'b1, 32'd0,        4'b0111, 1};
    tbl[9]  = '{4'd8,  32'd3,        32'd3,        1'b1, 32'd0,        4'b0100, 1};
    tbl[10] = '{4'd8,  32'd3,        32'd3,        1'b0, 32'hFFFFFFFF, 4'b1010, 1};
    tbl[11] = '{4'd6,  32'h80000000, 32'd0,        1'b0, 32'h80000000, 4'b1010, 1};
    tbl[12] = '{4'd6,  32'd0,        32'd7,        1'b0, 32'd0,        4'b0100, 1};
    tbl[13] = '{4'd9,  32'h00010000, 32'h00010000, 1'b0, 32'd0,        4'b0100, 33};
    tbl[14] = '{4'd10, 32'hFFFFFFFF, 32'd1,        1'b0, 32'hFFFFFFFF, 4'b0000, 33};
    tbl[15] = '{4'd11, 32'd7,        32'd100,      1'b0, 32'd7,        4'b0000, 33};
    tbl[16] = '{4'd14, 32'd5,        32'd3,        1'b0, 32'd1,        4'b0000, 1};
    tbl[17] = '{4'd12, 32'h12345678, 32'd0,        1'b1, 32'd0,        4'b0000, 1};
    tbl[18] = '{4'd15, 32'd0,        32'h55,       1'b0, 32'd0,        4'b0100, 1};
    tbl[19] = '{4'd7,  32'h80000000, 32'd1,        1'b0, 32'h80000001, 4'b1000, 1};

    bus.start = 1'b0; bus.control = '0; bus.channel_A = '0; bus.channel_B = '0; bus.CarryIn = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset out", bus.outputALU, 32'd0);
    chk("reset flags", 32'(flags_now()), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cin, r, f, lat);
      chk($sformatf("tbl%0d res", i), r, tbl[i].res);
      chk($sformatf("tbl%0d nzcv", i), 32'(f), 32'(tbl[i].nzcv));
      chk($sformatf("tbl%0d latency", i), 32'(lat), 32'(tbl[i].lat));
    end

    // ADD issued while a MUL is busy must be dropped; operands also change.
    @(negedge clock);
    bus.start = 1'b1; bus.control = 4'd9; bus.channel_A = 32'hFFFFFFFF; bus.channel_B = 32'd2;
    @(posedge clock); #1;
    bus.start = 1'b0;
    cyc = 1; ndone = 0; first = 0; held = '0;
    repeat (40) begin
      if (bus.done) begin
        ndone++;
        if (first == 0) begin first = cyc; held = bus.outputALU; end
      end
      if (cyc == 4) begin
        chk("mul busy", 32'(bus.busy), 32'd1);
        bus.start = 1'b1; bus.control = 4'd2; bus.channel_A = 32'd1; bus.channel_B = 32'd1;
      end
      if (cyc == 5) bus.start = 1'b0;
      @(posedge clock); #1;
      cyc++;
    end
    chk("mul-ignore done count", 32'(ndone), 32'd1);
    chk("mul-ignore latency", 32'(first), 32'd33);
    chk("mul-ignore res", held, 32'hFFFFFFFE);
    chk("idle busy", 32'(bus.busy), 32'd0);

    // Back-to-back single-cycle ops: done every cycle, then result holds.
    @(negedge clock);
    bus.start = 1'b1; bus.control = 4'd2; bus.channel_A = 32'd1; bus.channel_B = 32'd2;
    @(posedge clock); #1;
    chk("b2b1 done", 32'(bus.done), 32'd1);
    chk("b2b1 res", bus.outputALU, 32'd3);
    @(negedge clock);
    bus.control = 4'd13; bus.channel_A = 32'hF0; bus.channel_B = 32'hFF;
    @(posedge clock); #1;
    chk("b2b2 done", 32'(bus.done), 32'd1);
    chk("b2b2 res", bus.outputALU, 32'h0F);
    @(negedge clock);
    bus.control = 4'd5; bus.channel_A = 32'd10; bus.channel_B = 32'd4;
    @(posedge clock); #1;
    chk("b2b3 done", 32'(bus.done), 32'd1);
    chk("b2b3 res", bus.outputALU, 32'd6);
    @(negedge clock);
    bus.start = 1'b0; bus.channel_A = 32'hDEAD; bus.channel_B = 32'hBEEF;
    repeat (3) @(posedge clock);
    #1;
    chk("hold done", 32'(bus.done), 32'd0);
    chk("hold res", bus.outputALU, 32'd6);
    chk("hold flags", 32'(flags_now()), 32'd0);

    // Reset in the middle of a division.
    run_op(4'd2, 32'hFFFFFFFF, 32'h1, 1'b0, r, f, lat);
    chk("pre-reset flags", 32'(f), 32'b0111);
    @(negedge clock);
    bus.start = 1'b1; bus.control = 4'd10; bus.channel_A = 32'd100; bus.channel_B = 32'd7;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    chk("div busy", 32'(bus.busy), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("midreset busy", 32'(bus.busy), 32'd0);
    chk("midreset done", 32'(bus.done), 32'd0);
    chk("midreset out", bus.outputALU, 32'd0);
    chk("midreset flags", 32'(flags_now()), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (bus.done) ndone++;
    end
    chk("midreset stray done", 32'(ndone), 32'd0);
    run_op(4'd11, 32'd100, 32'd7, 1'b0, r, f, lat);
    chk("post-reset mod res", r, 32'd2);
    chk("post-reset mod latency", 32'(lat), 32'd33);

    // Random ops against the reference model.
    for (int i = 0; i < 150; i++) begin
      op  = 4'($urandom_range(0, 15));
      a   = $urandom;
      b   = $urandom;
      cin = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 20));
      if ($urandom_range(0, 7) == 0) a = 32'($urandom_range(0, 3));
      model(op, a, b, cin, er, ef, el);
      run_op(op, a, b, cin, r, f, lat);
      chk($sformatf("rand%0d op%0d res", i, op), r, er);
      chk($sformatf("rand%0d op%0d nzcv", i, op), 32'(f), 32'(ef));
      chk($sformatf("rand%0d op%0d latency", i, op), 32'(lat), 32'(el));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
